// File: rtl/lif_stdp_pair.sv
// Presynaptic and postsynaptic LIF neurons joined by one synapse with windowed STDP.
// Optional per-neuron refractory period: define LIF_REFRACTORY_EN.
module lif_stdp_pair #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned THRESHOLD  = 128,
    parameter int unsigned BETA_SHIFT = 3,
    parameter int unsigned WINDOW     = 7,
    parameter int unsigned STEP_SHIFT = 1,
    parameter int unsigned W_INIT     = 64,
    parameter int unsigned W_MAX      = 255,
    parameter int unsigned REFRACTORY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] pre_current,
    input  logic [WIDTH-1:0] post_bias,
    input  logic             learn_en,
    output logic             pre_spike,
    output logic             post_spike,
    output logic [WIDTH-1:0] pre_state,
    output logic [WIDTH-1:0] post_state,
    output logic [WIDTH-1:0] weight,
    output logic             w_updated
);
    localparam int unsigned EW = WIDTH + 1;
    localparam int unsigned TW = $clog2(WINDOW + 2);
    localparam logic [TW-1:0] TIMER_IDLE = TW'(WINDOW + 1);
    localparam logic [TW-1:0] WIN        = TW'(WINDOW);
    localparam logic [EW-1:0] THR        = EW'(THRESHOLD);
    localparam logic [EW-1:0] W_MAX_E    = EW'(W_MAX);

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [EW-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] leak(input logic [WIDTH-1:0] s);
        return s - (s >> BETA_SHIFT);
    endfunction

    // Larger step for tighter spike pairs; dt is only used when dt <= WINDOW.
    function automatic logic [EW-1:0] step_size(input logic [TW-1:0] dt);
        logic [TW-1:0] gap;
        gap = WIN - dt;
        return EW'(gap >> STEP_SHIFT) + EW'(1);
    endfunction

    logic [TW-1:0]    pre_timer, post_timer, pre_timer_d, post_timer_d;
    logic [WIDTH-1:0] pre_state_d, post_state_d, weight_d;
    logic             pre_spike_d, post_spike_d, w_updated_d;
    logic [WIDTH-1:0] pre_sum, post_in, post_sum;
    logic             pre_fire, post_fire, pre_block, post_block, ltp, ltd;
    logic [EW-1:0]    w_ext, inc, dec, w_up;

    assign pre_sum   = sat_add(leak(pre_state), pre_current);
    assign post_in   = sat_add(post_bias, pre_spike ? weight : '0);
    assign post_sum  = sat_add(leak(post_state), post_in);
    assign pre_fire  = {1'b0, pre_sum} >= THR;
    assign post_fire = {1'b0, post_sum} >= THR;

    assign ltp   = learn_en && post_spike && !pre_spike && (pre_timer <= WIN);
    assign ltd   = learn_en && pre_spike && !post_spike && (post_timer <= WIN);
    assign w_ext = {1'b0, weight};
    assign inc   = step_size(pre_timer);
    assign dec   = step_size(post_timer);
    assign w_up  = w_ext + inc;

`ifdef LIF_REFRACTORY_EN
    localparam int unsigned RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    logic [RW-1:0] pre_refr, post_refr, pre_refr_d, post_refr_d;
    assign pre_block  = pre_refr != '0;
    assign post_block = post_refr != '0;
`else
    assign pre_block  = 1'b0;
    assign post_block = 1'b0;
`endif

    // Next-state: hold everything and drop one-cycle events while frozen.
    always_comb begin
        pre_state_d  = pre_state;
        post_state_d = post_state;
        pre_timer_d  = pre_timer;
        post_timer_d = post_timer;
        weight_d     = weight;
        pre_spike_d  = 1'b0;
        post_spike_d = 1'b0;
        w_updated_d  = 1'b0;
`ifdef LIF_REFRACTORY_EN
        pre_refr_d   = pre_refr;
        post_refr_d  = post_refr;
`endif
        if (ena) begin
            if (pre_block || pre_fire) begin
                pre_state_d = '0;
                pre_spike_d = !pre_block;
            end else begin
                pre_state_d = pre_sum;
            end
            if (post_block || post_fire) begin
                post_state_d = '0;
                post_spike_d = !post_block;
            end else begin
                post_state_d = post_sum;
            end
`ifdef LIF_REFRACTORY_EN
            if (pre_block)     pre_refr_d  = pre_refr - RW'(1);
            else if (pre_fire) pre_refr_d  = RW'(REFRACTORY);
            if (post_block)     post_refr_d = post_refr - RW'(1);
            else if (post_fire) post_refr_d = RW'(REFRACTORY);
`endif
            if (pre_spike)                  pre_timer_d = '0;
            else if (pre_timer < TIMER_IDLE) pre_timer_d = pre_timer + TW'(1);
            if (post_spike)                  post_timer_d = '0;
            else if (post_timer < TIMER_IDLE) post_timer_d = post_timer + TW'(1);

            if (ltp) weight_d = WIDTH'((w_up > W_MAX_E) ? W_MAX_E : w_up);
            if (ltd) weight_d = WIDTH'((dec > w_ext) ? '0 : (w_ext - dec));
            w_updated_d = ltp || ltd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_state  <= '0;
            post_state <= '0;
            pre_spike  <= 1'b0;
            post_spike <= 1'b0;
            pre_timer  <= TIMER_IDLE;
            post_timer <= TIMER_IDLE;
            weight     <= WIDTH'(W_INIT);
            w_updated  <= 1'b0;
        end else begin
            pre_state  <= pre_state_d;
            post_state <= post_state_d;
            pre_spike  <= pre_spike_d;
            post_spike <= post_spike_d;
            pre_timer  <= pre_timer_d;
            post_timer <= post_timer_d;
            weight     <= weight_d;
            w_updated  <= w_updated_d;
        end
    end

`ifdef LIF_REFRACTORY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_refr  <= '0;
            post_refr <= '0;
        end else begin
            pre_refr  <= pre_refr_d;
            post_refr <= post_refr_d;
        end
    end
`endif

endmodule

// File: doc/lif_stdp_pair.md
Name: lif_stdp_pair

Overview:
- Parametrised successor to the single fixed-width LIF cell: a presynaptic and a postsynaptic leaky integrate-and-fire neuron joined by one plastic synapse.
- Weight is updated on-chip by a windowed, timing-dependent STDP rule.
- Sits under the TinyTapeout top: ui_in drives the currents, uo_out and uio_out expose state, spikes and weight.

Parameters:
- WIDTH, 8, width of membrane state, input current and weight.
- THRESHOLD, 128, fire when integrated value >= THRESHOLD.
- BETA_SHIFT, 3, leak: leak(s) = s - (s >> BETA_SHIFT).
- WINDOW, 7, max spike-time difference (cycles) eligible for plasticity.
- STEP_SHIFT, 1, scales the time-dependent weight step.
- W_INIT, 64, weight after reset.
- W_MAX, 255, weight upper saturation; lower saturation is fixed at 0.
- REFRACTORY, 2, refractory cycles (used only with REFRACTORY_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  advance enable; low freezes the block.
- pre_current  in  WIDTH  drive current into the presynaptic neuron.
- post_bias  in  WIDTH  external bias current into the postsynaptic neuron.
- learn_en  in  1  enables weight updates.
- pre_spike  out  1  registered presynaptic spike.
- post_spike  out  1  registered postsynaptic spike.
- pre_state  out  WIDTH  presynaptic membrane state.
- post_state  out  WIDTH  postsynaptic membrane state.
- weight  out  WIDTH  current synaptic weight.
- w_updated  out  1  one-cycle pulse when the STDP rule fires.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - states = 0, spikes = 0, w_updated = 0, weight = W_INIT.
  - Internal pre_timer and post_timer = WINDOW+1, meaning "no recent spike".
- Neuron update, per rising edge with ena = 1:
  - sum = leak(state) + input, saturating at 2^WIDTH-1.
  - If sum >= THRESHOLD: state <= 0 and spike <= 1. Otherwise state <= sum and spike <= 0.
- Neuron inputs:
  - Presynaptic input = pre_current.
  - Postsynaptic input = post_bias + (pre_spike ? weight : 0), saturating.
  - Uses the registered pre_spike, so the synaptic delay is 1 cycle.
- Timers, per enabled edge:
  - If the corresponding spike register is 1, timer <= 0.
  - Otherwise timer <= min(timer+1, WINDOW+1).
  - A spike visible in cycle t gives timer = k-1 in cycle t+k.
- STDP rule: evaluated on enabled edges with learn_en = 1, using pre-edge timer values.
  - Step size: delta(dt) = ((WINDOW - dt) >> STEP_SHIFT) + 1.
  - LTP: post_spike = 1, pre_spike = 0, pre_timer <= WINDOW → weight <= min(weight + delta(pre_timer), W_MAX).
  - LTD: pre_spike = 1, post_spike = 0, post_timer <= WINDOW → weight <= max(weight - delta(post_timer), 0).
  - Both spikes high in the same cycle: no weight change; both timers reset.
  - w_updated <= 1 for one cycle whenever LTP or LTD fires, even if saturation leaves the weight unchanged. Otherwise w_updated <= 0.
- ena = 0:
  - States, timers and weight hold.
  - pre_spike, post_spike and w_updated are forced to 0 on that edge, so no event is repeated.
- learn_en = 0: neurons and timers run; weight holds; w_updated stays 0.
- Reset mid-operation: all registers return to their reset values immediately; an in-flight spike or update is discarded.
- Arithmetic: all add/subtract operations use WIDTH+1 bits internally before saturation; no wrap-around is permitted anywhere.

Optional Feature:
- Macro: LIF_REFRACTORY_EN.
- Defined: after a spike, each neuron runs a per-neuron counter loaded with REFRACTORY.
  - While the counter is nonzero, state is held at 0, input is ignored and no spike can occur.
  - The counter decrements on each enabled edge.
- Undefined: no counter is instantiated; a neuron can integrate on the very next cycle after firing.

Test Plan:
- Reset: assert rst_n = 0 mid-run with pre_current = 40 → states 0, spikes 0, weight = 64, w_updated = 0, asynchronously (before the next edge).
- Integration: pre_current = 40, post_bias = 0 from reset → pre_state goes 40, 75, 106, then pre_spike = 1 on the 4th edge with pre_state = 0; the pattern repeats.
- LTP: pre spike in cycle t, post spike forced via post_bias = 128 for one cycle so post_spike appears in t+3 → dt = 2, delta = 3, weight 64 → 67, w_updated pulses once.
- LTD: post spike in cycle t, pre spike in t+1 → dt = 0, delta = 4, weight 64 → 60. The same pair with learn_en = 0 → weight stays 64.
- Saturation and boundaries:
  - Weight 254 with LTP delta 3 → 255.
  - Weight 2 with LTD delta 4 → 0.
  - Pair separated by 9 cycles (dt = 8 > WINDOW) → no change, no w_updated.
  - Simultaneous pre/post spike → no change.
- Freeze and refractory:
  - ena = 0 for 5 cycles mid-integration → all state holds, spikes 0; operation resumes unchanged.
  - With LIF_REFRACTORY_EN and pre_current = 200 → pre_spike every 3rd cycle instead of every cycle.
